// File: rtl/z16_led_ctrl.sv
// Memory-mapped LED controller: LED_COUNT channels, each off / on / blink / PWM.
// Optional build macro Z16_LED_ACTIVE_LOW_EN inverts o_led and makes it reset to all ones.
module z16_led_ctrl #(
  parameter int LED_COUNT = 6,
  parameter int ADDR_W    = 4,
  parameter int PWM_BITS  = 4,
  parameter int BLINK_DIV = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [15:0]          i_wdata,
  output logic [15:0]          o_rdata,
  output logic                 o_rvalid,
  output logic [LED_COUNT-1:0] o_led
);

  localparam int CH_W = PWM_BITS + 2;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

`ifdef Z16_LED_ACTIVE_LOW_EN
  localparam logic [LED_COUNT-1:0] LED_POL = '1;
`else
  localparam logic [LED_COUNT-1:0] LED_POL = '0;
`endif

  logic [CH_W-1:0]      ch_reg [LED_COUNT];
  logic [PWM_BITS-1:0]  pwm_cnt_reg;
  logic [BLINK_DIV-1:0] blink_cnt_reg;
  logic                 blink_phase_reg;
  logic [LED_COUNT-1:0] led_next;
  logic [CH_W-1:0]      rdata_next;

  // Upper write-data bits have no storage behind them.
  logic unused_wdata;
  assign unused_wdata = ^i_wdata[15:CH_W];

  // Free-running timebase shared by all channels; writes never restart it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pwm_cnt_reg     <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      pwm_cnt_reg   <= pwm_cnt_reg + 1'b1;
      blink_cnt_reg <= blink_cnt_reg + 1'b1;
      if (blink_cnt_reg == '1) begin
        blink_phase_reg <= ~blink_phase_reg;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < LED_COUNT; gi++) begin : g_ch
      mode_t               mode;
      logic [PWM_BITS-1:0] duty;

      // Address decode per channel: out-of-range addresses match no channel.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          ch_reg[gi] <= '0;
        end else if (i_we && (i_addr == ADDR_W'(gi))) begin
          ch_reg[gi] <= i_wdata[CH_W-1:0];
        end
      end

      assign mode = mode_t'(ch_reg[gi][1:0]);
      assign duty = ch_reg[gi][CH_W-1:2];

      always_comb begin
        led_next[gi] = 1'b0;
        case (mode)
          MODE_OFF:   led_next[gi] = 1'b0;
          MODE_ON:    led_next[gi] = 1'b1;
          MODE_BLINK: led_next[gi] = blink_phase_reg;
          MODE_PWM:   led_next[gi] = (pwm_cnt_reg < duty);
          default:    led_next[gi] = 1'b0;
        endcase
      end
    end
  endgenerate

  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < LED_COUNT; i++) begin
      if (i_addr == ADDR_W'(i)) begin
        rdata_next = ch_reg[i];
      end
    end
  end

  // Read samples the register before any same-edge write lands (read-before-write).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_led    <= LED_POL;
    end else begin
      o_rvalid <= i_re;
      o_rdata  <= i_re ? {{(16-CH_W){1'b0}}, rdata_next} : 16'h0000;
      o_led    <= led_next ^ LED_POL;
    end
  end

endmodule

// File: tb/tb_z16_led_ctrl.sv
// Directed self-checking bench for z16_led_ctrl with default parameters.
// Expectations follow the Z16_LED_ACTIVE_LOW_EN build macro when it is defined.
module tb_z16_led_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_we = 1'b0;
  logic        i_re = 1'b0;
  logic [3:0]  i_addr = '0;
  logic [15:0] i_wdata = '0;
  logic [15:0] o_rdata;
  logic        o_rvalid;
  logic [5:0]  o_led;

  int checks = 0;
  int errors = 0;

`ifdef Z16_LED_ACTIVE_LOW_EN
  localparam logic [5:0] POL = 6'b111111;
`else
  localparam logic [5:0] POL = 6'b000000;
`endif

  z16_led_ctrl dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (i_we),
    .i_re    (i_re),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_rvalid(o_rvalid),
    .o_led   (o_led)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_write(input logic [3:0] a, input logic [15:0] d);
    i_we = 1'b1; i_addr = a; i_wdata = d;
    @(negedge i_clk);
    i_we = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a);
    i_re = 1'b1; i_addr = a;
    @(negedge i_clk);
    i_re = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    checks++;
    if (o_led !== (POL ^ 6'b000000) || o_rvalid !== 1'b0 || o_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_idle: led=%b rvalid=%b rdata=%h want led=%b rvalid=0 rdata=0000", o_led, o_rvalid, o_rdata, POL);
    end
    do_write(4'd0, 16'h0001);
    @(negedge i_clk);
    checks++;
    if (o_led !== (POL ^ 6'b000001)) begin
      errors++;
      $display("FAIL reset_pre_on: led=%b want %b", o_led, POL ^ 6'b000001);
    end
    do_read(4'd0);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0001) begin
      errors++;
      $display("FAIL reset_pre_read: rvalid=%b rdata=%h want 1 0001", o_rvalid, o_rdata);
    end
    // Assert reset between clock edges: outputs must clear without an edge.
    #2 i_rst = 1'b1;
    #1;
    checks++;
    if (o_led !== (POL ^ 6'b000000) || o_rvalid !== 1'b0 || o_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: led=%b rvalid=%b rdata=%h want led=%b rvalid=0 rdata=0000", o_led, o_rvalid, o_rdata, POL);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    do_read(4'd0);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL reset_readback: rvalid=%b rdata=%h want 1 0000", o_rvalid, o_rdata);
    end
  endtask

  task automatic test_on_off();
    do_write(4'd2, 16'h0001);
    do_write(4'd5, 16'h0001);
    @(negedge i_clk);
    checks++;
    if (o_led !== (POL ^ 6'b100100)) begin
      errors++;
      $display("FAIL on_two: led=%b want %b", o_led, POL ^ 6'b100100);
    end
    do_write(4'd2, 16'h0000);
    @(negedge i_clk);
    checks++;
    if (o_led !== (POL ^ 6'b100000)) begin
      errors++;
      $display("FAIL off_ch2: led=%b want %b", o_led, POL ^ 6'b100000);
    end
    do_write(4'd5, 16'h0000);
  endtask

  // Reset is released with a blink write already pending so it lands on edge 1.
  // After edge k, o_led[0] reflects blink_phase before that edge: ((k-1)/8) % 2.
  task automatic test_blink();
    logic exp_bit;
    @(negedge i_clk);
    i_rst = 1'b1;
    i_we = 1'b1; i_addr = 4'd0; i_wdata = 16'h0002;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge i_clk);
      i_we = 1'b0;
      exp_bit = (((k - 1) / 8) % 2) == 1;
      checks++;
      if (o_led[0] !== (exp_bit ^ POL[0])) begin
        errors++;
        $display("FAIL blink_cycle%0d: led0=%b want %b", k - 1, o_led[0], exp_bit ^ POL[0]);
      end
    end
    do_write(4'd0, 16'h0000);
  endtask

  // High count over any 16 consecutive cycles must equal duty.
  task automatic test_pwm();
    logic [15:0] vals [3] = '{16'h0013, 16'h0003, 16'h003F};
    int          duty [3] = '{4, 0, 15};
    int          highs;
    for (int t = 0; t < 3; t++) begin
      do_write(4'd1, vals[t]);
      highs = 0;
      for (int c = 0; c < 16; c++) begin
        @(negedge i_clk);
        if ((o_led[1] ^ POL[1]) === 1'b1) highs++;
      end
      checks++;
      if (highs !== duty[t]) begin
        errors++;
        $display("FAIL pwm_duty%0d: high_cycles=%0d want %0d", duty[t], highs, duty[t]);
      end
    end
    do_write(4'd1, 16'h0000);
  endtask

  task automatic test_bus();
    do_write(4'd3, 16'hFFFF);
    do_read(4'd3);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h003F) begin
      errors++;
      $display("FAIL bus_read3: rvalid=%b rdata=%h want 1 003f", o_rvalid, o_rdata);
    end
    @(negedge i_clk);
    checks++;
    if (o_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL bus_rvalid_drop: rvalid=%b want 0", o_rvalid);
    end
    // Same-edge read and write of addr 3 returns the old contents.
    i_we = 1'b1; i_re = 1'b1; i_addr = 4'd3; i_wdata = 16'h0001;
    @(negedge i_clk);
    i_we = 1'b0; i_re = 1'b0;
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h003F) begin
      errors++;
      $display("FAIL bus_rbw_old: rvalid=%b rdata=%h want 1 003f", o_rvalid, o_rdata);
    end
    // Back-to-back reads: addr 3 then out-of-range addr 9.
    i_re = 1'b1; i_addr = 4'd3;
    @(negedge i_clk);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0001) begin
      errors++;
      $display("FAIL bus_rbw_new: rvalid=%b rdata=%h want 1 0001", o_rvalid, o_rdata);
    end
    i_addr = 4'd9;
    @(negedge i_clk);
    i_re = 1'b0;
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL bus_b2b_oor: rvalid=%b rdata=%h want 1 0000", o_rvalid, o_rdata);
    end
    do_write(4'd9, 16'h0001);
    do_read(4'd9);
    checks++;
    if (o_rvalid !== 1'b1 || o_rdata !== 16'h0000) begin
      errors++;
      $display("FAIL bus_read9: rvalid=%b rdata=%h want 1 0000", o_rvalid, o_rdata);
    end
    checks++;
    if (o_led !== (POL ^ 6'b001000)) begin
      errors++;
      $display("FAIL bus_write9_ignored: led=%b want %b", o_led, POL ^ 6'b001000);
    end
    for (int a = 0; a < 6; a++) begin
      do_read(4'(a));
      checks++;
      if (o_rdata !== ((a == 3) ? 16'h0001 : 16'h0000)) begin
        errors++;
        $display("FAIL bus_scan%0d: rdata=%h want %h", a, o_rdata, (a == 3) ? 16'h0001 : 16'h0000);
      end
    end
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_pwm();
    test_bus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/z16_led_ctrl.md
Name: z16_led_ctrl

Overview:
- Parametrised, memory-mapped LED output controller for the Z16 CPU.
- Generalises the fixed 6-bit LED port to LED_COUNT channels.
- Each channel has its own mode: off, on, blink or PWM dimming.
- Sits on the CPU data-bus store/load path; drives board LEDs directly through o_led.

Parameters:
- LED_COUNT, 6, number of LED channels (1..16).
- ADDR_W, 4, register address width; 2^ADDR_W must be >= LED_COUNT.
- PWM_BITS, 4, PWM counter and duty width (1..8).
- BLINK_DIV, 3, blink prescaler width; blink half-period is 2^BLINK_DIV cycles.

Ports:
- i_clk, input, 1, system clock.
- i_rst, input, 1, asynchronous active-high reset.
- i_we, input, 1, write strobe, one cycle per write.
- i_re, input, 1, read strobe, one cycle per read.
- i_addr, input, ADDR_W, channel register index.
- i_wdata, input, 16, write data.
- o_rdata, output, 16, registered read data.
- o_rvalid, output, 1, o_rdata valid this cycle.
- o_led, output, LED_COUNT, LED drive, one bit per channel.

Behaviour:
- Reset is asynchronous and active-high. While i_rst is high, all of the following are cleared to 0: channel registers, pwm_cnt, blink_cnt, blink_phase, o_led, o_rdata, o_rvalid.
- Reset asserted mid-operation clears everything immediately. No write in progress survives it.
- Channel register ch has width 2+PWM_BITS:
  - [1:0] mode: 00 off, 01 on, 10 blink, 11 pwm.
  - [PWM_BITS+1:2] duty.
- Write: when i_we=1 at an edge and i_addr < LED_COUNT, channel[i_addr] <= i_wdata[PWM_BITS+1:0]. Upper wdata bits are ignored.
- A write with i_addr >= LED_COUNT is ignored.
- Read: when i_re=1 at edge N:
  - o_rvalid=1 and o_rdata={zero-extend, channel[i_addr]} during cycle N+1.
  - o_rdata=0 for out-of-range addresses.
  - o_rvalid returns to 0 on the next edge unless i_re is held. Back-to-back reads are allowed, one per cycle.
- Read and write in the same cycle to the same address: the read returns the old value (read-before-write).
- pwm_cnt is PWM_BITS wide, increments every cycle and wraps from all-ones to 0.
- blink_cnt is BLINK_DIV wide, increments every cycle. blink_phase toggles on the edge where blink_cnt wraps from all-ones to 0.
- Both counters are free-running from reset and are never restarted by writes.
- Per-channel level:
  - off: 0
  - on: 1
  - blink: blink_phase
  - pwm: (pwm_cnt < duty), unsigned compare. duty=0 gives always 0; duty=2^PWM_BITS-1 gives 0 for one cycle per period.
- o_led is registered from the level computed on the current counter and register values.
- Latency: a write at edge N is visible on o_led from edge N+1.
- Channels are fully independent. No cross-channel state.

Optional Feature:
- Macro: Z16_LED_ACTIVE_LOW_EN.
- Defined: o_led is the bitwise inverse of the level above, and o_led resets to all ones (LEDs dark on active-low boards).
- Undefined: active-high drive, and o_led resets to 0.
- Register read-back is identical in both builds.

Test Plan (defaults; macro undefined unless stated):
- Reset: assert i_rst mid-run with channel 0 = on. o_led=6'b000000 and o_rvalid=0 immediately, without waiting for a clock edge. Read of addr 0 after release returns 0x0000.
- On/off: write addr 2 = 0x0001, addr 5 = 0x0001. o_led=6'b100100 from the edge after the second write. Then write addr 2 = 0x0000 → o_led=6'b100000.
- Blink: write addr 0 = 0x0002 before cycle 8 after reset. o_led[0] is 0 for cycles 0-7, 1 for cycles 8-15, 0 for cycles 16-23, using cycle indices counted from reset release.
- PWM: write addr 1 = (duty 4 << 2)|3 = 0x0013. o_led[1] is high for exactly 4 of every 16 cycles. Then write duty 0 → always low; then duty 15 (0x003F) → high 15 of 16 cycles.
- Bus: write addr 3 = 0xFFFF, then read addr 3 → o_rvalid=1 one cycle later, o_rdata=0x003F. Write addr 9 = 0x0001 changes nothing. Read addr 9 → o_rdata=0x0000, o_rvalid=1. Same-cycle read+write on addr 3 returns the old value.
- Active-low build: compile with Z16_LED_ACTIVE_LOW_EN. o_led=6'b111111 in reset. Channel 2 on → o_led=6'b111011.
